// File: rtl/lsu_dc_wr_arb.sv
// -----------------------------------------------------------------------------
// lsu_dc_wr_arb
//
// Arbitrates the single D$ data-array write port between two requesters:
//   - retired stores leaving the store queue (SQ), one beat each
//   - MSHQ line fills, delivered as multi-beat bursts
//
// The MSHQ normally wins. Once a fill burst has started (first beat accepted
// with last=0), the port is reserved for the MSHQ until the beat carrying
// last=1 is accepted. A starvation counter tracks how many fill bursts have
// completed while a store was waiting. When it reaches STARVE_LIMIT, the next
// arbitration in ARB goes to the SQ.
//
// The write is presented from a registered output stage. A request accepted
// in cycle N appears on o_dc_wr_* in cycle N+1. While the output register is
// full and the D$ stalls, everything holds and neither requester is accepted.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   i_sq_req_*         SQ store request (valid/data/addr/byte enables)
//   o_sq_req_ready     SQ request accepted this cycle
//   i_mshq_*           fill beat (valid/data/addr/byte enables/last)
//   o_mshq_ready       fill beat accepted this cycle
//   i_dc_wr_stall      D$ cannot take the presented write this cycle
//   o_dc_wr_en         output register holds a valid write
//   o_dc_wr_data/addr/width
//                      write payload
//   o_dc_wr_src        0 = SQ, 1 = MSHQ
// -----------------------------------------------------------------------------
module lsu_dc_wr_arb #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_sq_req_valid,
    input  logic [DATA_WIDTH-1:0] i_sq_req_data,
    input  logic [ADDR_WIDTH-1:0] i_sq_req_addr,
    input  logic [3:0]            i_sq_req_width,
    output logic                  o_sq_req_ready,

    input  logic                  i_mshq_valid,
    input  logic [DATA_WIDTH-1:0] i_mshq_data,
    input  logic [ADDR_WIDTH-1:0] i_mshq_addr,
    input  logic [3:0]            i_mshq_width,
    input  logic                  i_mshq_last,
    output logic                  o_mshq_ready,

    input  logic                  i_dc_wr_stall,
    output logic                  o_dc_wr_en,
    output logic [DATA_WIDTH-1:0] o_dc_wr_data,
    output logic [ADDR_WIDTH-1:0] o_dc_wr_addr,
    output logic [3:0]            o_dc_wr_width,
    output logic                  o_dc_wr_src
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);
    localparam logic [STARVE_WIDTH-1:0] STARVE_ONE = STARVE_WIDTH'(1);
    localparam logic [STARVE_WIDTH-1:0] STARVE_ZERO = STARVE_WIDTH'(0);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [STARVE_WIDTH-1:0] starve_cnt_r;
    logic [STARVE_WIDTH-1:0] starve_cnt_nxt_s;

    logic advance_s;
    logic force_sq_s;
    logic grant_sq_s;
    logic grant_m_s;
    logic sq_acc_s;
    logic m_acc_s;

    // Grant decision: MSHQ first, SQ only in ARB and only if MSHQ idle or SQ starved.
    always_comb begin
        advance_s  = ~o_dc_wr_en | ~i_dc_wr_stall;
        force_sq_s = (starve_cnt_r == STARVE_MAX);
        grant_sq_s = (state_r == ST_ARB) & i_sq_req_valid & (~i_mshq_valid | force_sq_s);
        grant_m_s  = i_mshq_valid & ~grant_sq_s;
        // Readies are suppressed during reset so nothing is consumed and lost.
        sq_acc_s   = ~rst & advance_s & grant_sq_s;
        m_acc_s    = ~rst & advance_s & grant_m_s;
    end

    assign o_sq_req_ready = sq_acc_s;
    assign o_mshq_ready   = m_acc_s;

    // Next-state logic: a fill beat with last=0 reserves the port until last=1.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ARB: begin
                if (m_acc_s && !i_mshq_last) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_BURST: begin
                // Bubbles (no MSHQ valid) keep the reservation; SQ stays blocked.
                if (m_acc_s && i_mshq_last) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
    end

    // Starvation counter: counts completed fills that overtook a waiting store.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (sq_acc_s) begin
            starve_cnt_nxt_s = STARVE_ZERO;
        end else if ((state_r == ST_ARB) && !i_sq_req_valid) begin
            starve_cnt_nxt_s = STARVE_ZERO;
        end else if (m_acc_s && i_mshq_last && i_sq_req_valid) begin
            if (starve_cnt_r != STARVE_MAX) begin
                starve_cnt_nxt_s = starve_cnt_r + STARVE_ONE;
            end else begin
                starve_cnt_nxt_s = starve_cnt_r;
            end
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_ARB;
            starve_cnt_r <= STARVE_ZERO;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // Output register: loads the winner on advance, drains when nothing won,
    // holds everything while the D$ stalls a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_dc_wr_en    <= 1'b0;
            o_dc_wr_data  <= {DATA_WIDTH{1'b0}};
            o_dc_wr_addr  <= {ADDR_WIDTH{1'b0}};
            o_dc_wr_width <= 4'h0;
            o_dc_wr_src   <= 1'b0;
        end else if (advance_s) begin
            if (sq_acc_s) begin
                o_dc_wr_en    <= 1'b1;
                o_dc_wr_data  <= i_sq_req_data;
                o_dc_wr_addr  <= i_sq_req_addr;
                o_dc_wr_width <= i_sq_req_width;
                o_dc_wr_src   <= 1'b0;
            end else if (m_acc_s) begin
                o_dc_wr_en    <= 1'b1;
                o_dc_wr_data  <= i_mshq_data;
                o_dc_wr_addr  <= i_mshq_addr;
                o_dc_wr_width <= i_mshq_width;
                o_dc_wr_src   <= 1'b1;
            end else begin
                o_dc_wr_en    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dc_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_lsu_dc_wr_arb
//
// Directed scenarios followed by a randomized run. A transaction-level model
// (winner choice, fill-in-progress flag, starvation count, expected output
// write) predicts readies and the output write every cycle.
// -----------------------------------------------------------------------------
module tb_lsu_dc_wr_arb;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_sq_req_valid;
    logic [DW-1:0] i_sq_req_data;
    logic [AW-1:0] i_sq_req_addr;
    logic [3:0]    i_sq_req_width;
    logic          o_sq_req_ready;
    logic          i_mshq_valid;
    logic [DW-1:0] i_mshq_data;
    logic [AW-1:0] i_mshq_addr;
    logic [3:0]    i_mshq_width;
    logic          i_mshq_last;
    logic          o_mshq_ready;
    logic          i_dc_wr_stall;
    logic          o_dc_wr_en;
    logic [DW-1:0] o_dc_wr_data;
    logic [AW-1:0] o_dc_wr_addr;
    logic [3:0]    o_dc_wr_width;
    logic          o_dc_wr_src;

    lsu_dc_wr_arb #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(LIM),
        .STARVE_WIDTH(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_sq_req_valid(i_sq_req_valid),
        .i_sq_req_data (i_sq_req_data),
        .i_sq_req_addr (i_sq_req_addr),
        .i_sq_req_width(i_sq_req_width),
        .o_sq_req_ready(o_sq_req_ready),
        .i_mshq_valid  (i_mshq_valid),
        .i_mshq_data   (i_mshq_data),
        .i_mshq_addr   (i_mshq_addr),
        .i_mshq_width  (i_mshq_width),
        .i_mshq_last   (i_mshq_last),
        .o_mshq_ready  (o_mshq_ready),
        .i_dc_wr_stall (i_dc_wr_stall),
        .o_dc_wr_en    (o_dc_wr_en),
        .o_dc_wr_data  (o_dc_wr_data),
        .o_dc_wr_addr  (o_dc_wr_addr),
        .o_dc_wr_width (o_dc_wr_width),
        .o_dc_wr_src   (o_dc_wr_src)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit            mdl_in_fill;
    int            mdl_starve;
    bit            mdl_en;
    logic [DW-1:0] mdl_data;
    logic [AW-1:0] mdl_addr;
    logic [3:0]    mdl_width;
    bit            mdl_src;
    bit            last_sq_acc;
    bit            last_m_acc;
    string         trace;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already driven. Check readies mid-cycle, advance
    // the model at the edge, then check the registered write just after it.
    task automatic cycle();
        bit port_free;
        bit sq_wins;
        bit m_wins;
        bit acc_sq;
        bit acc_m;
        #1;
        port_free = !mdl_en || !i_dc_wr_stall;
        sq_wins   = !mdl_in_fill && i_sq_req_valid && (!i_mshq_valid || mdl_starve == LIM);
        m_wins    = i_mshq_valid && !sq_wins;
        acc_sq    = !rst && port_free && sq_wins;
        acc_m     = !rst && port_free && m_wins;
        check("sq_ready", {63'd0, o_sq_req_ready}, {63'd0, acc_sq});
        check("mshq_ready", {63'd0, o_mshq_ready}, {63'd0, acc_m});
        if (o_sq_req_ready) trace = {trace, "S"};
        else if (o_mshq_ready) trace = {trace, "M"};
        else trace = {trace, "-"};
        last_sq_acc = acc_sq;
        last_m_acc  = acc_m;
        @(posedge clk);
        if (rst) begin
            mdl_in_fill = 1'b0;
            mdl_starve  = 0;
            mdl_en      = 1'b0;
            mdl_data    = '0;
            mdl_addr    = '0;
            mdl_width   = 4'h0;
            mdl_src     = 1'b0;
        end else begin
            if (!mdl_in_fill && !i_sq_req_valid) mdl_starve = 0;
            if (acc_sq) begin
                mdl_starve = 0;
                mdl_en     = 1'b1;
                mdl_data   = i_sq_req_data;
                mdl_addr   = i_sq_req_addr;
                mdl_width  = i_sq_req_width;
                mdl_src    = 1'b0;
            end else if (acc_m) begin
                mdl_en      = 1'b1;
                mdl_data    = i_mshq_data;
                mdl_addr    = i_mshq_addr;
                mdl_width   = i_mshq_width;
                mdl_src     = 1'b1;
                mdl_in_fill = !i_mshq_last;
                if (i_mshq_last && i_sq_req_valid && mdl_starve < LIM) mdl_starve = mdl_starve + 1;
            end else if (port_free) begin
                mdl_en = 1'b0;
            end
        end
        #1;
        check("wr_en", {63'd0, o_dc_wr_en}, {63'd0, mdl_en});
        check("wr_data", {32'd0, o_dc_wr_data}, {32'd0, mdl_data});
        check("wr_addr", {32'd0, o_dc_wr_addr}, {32'd0, mdl_addr});
        check("wr_width", {60'd0, o_dc_wr_width}, {60'd0, mdl_width});
        check("wr_src", {63'd0, o_dc_wr_src}, {63'd0, mdl_src});
    endtask

    task automatic new_sq(input bit v);
        i_sq_req_valid = v;
        i_sq_req_data  = $urandom;
        i_sq_req_addr  = $urandom;
        i_sq_req_width = 4'($urandom_range(15));
    endtask

    task automatic new_m(input bit v, input bit last);
        i_mshq_valid = v;
        i_mshq_data  = $urandom;
        i_mshq_addr  = $urandom;
        i_mshq_width = 4'($urandom_range(15));
        i_mshq_last  = last;
    endtask

    logic [DW-1:0] held_data;
    logic [AW-1:0] held_addr;

    initial begin
        mdl_in_fill = 1'b0;
        mdl_starve  = 0;
        mdl_en      = 1'b0;
        mdl_data    = '0;
        mdl_addr    = '0;
        mdl_width   = 4'h0;
        mdl_src     = 1'b0;
        trace       = "";
        rst           = 1'b1;
        i_dc_wr_stall = 1'b0;
        new_sq(1'b1);
        new_m(1'b1, 1'b1);

        // Reset with both requesters valid: nothing accepted, output empty.
        cycle();
        cycle();
        check("t1_rst_en", {63'd0, o_dc_wr_en}, 64'd0);
        rst   = 1'b0;
        trace = "";
        cycle();
        check_str("t1_first_grant", trace, "M");

        // Idle cycle also clears the starvation count.
        new_sq(1'b0);
        new_m(1'b0, 1'b1);
        cycle();

        // Single store reaches the write port one cycle after acceptance.
        i_sq_req_valid = 1'b1;
        i_sq_req_addr  = 32'h0000_0100;
        i_sq_req_data  = 32'hDEAD_BEEF;
        i_sq_req_width = 4'hF;
        cycle();
        check("t2_en", {63'd0, o_dc_wr_en}, 64'd1);
        check("t2_addr", {32'd0, o_dc_wr_addr}, 64'h100);
        check("t2_data", {32'd0, o_dc_wr_data}, 64'hDEAD_BEEF);
        check("t2_width", {60'd0, o_dc_wr_width}, 64'hF);
        check("t2_src", {63'd0, o_dc_wr_src}, 64'd0);

        // Both continuously valid, every fill is single-beat.
        new_sq(1'b1);
        new_m(1'b1, 1'b1);
        trace = "";
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_sq_acc) new_sq(1'b1);
            new_m(1'b1, 1'b1);
        end
        check_str("t3_order", trace, "MMMMSMMMMS");

        // Four-beat fill with a bubble; the waiting store is held off throughout.
        new_sq(1'b0);
        new_m(1'b0, 1'b0);
        cycle();
        new_sq(1'b1);
        trace = "";
        new_m(1'b1, 1'b0);
        cycle();
        new_m(1'b1, 1'b0);
        cycle();
        new_m(1'b0, 1'b0);
        cycle();
        new_m(1'b1, 1'b0);
        cycle();
        new_m(1'b1, 1'b1);
        cycle();
        new_m(1'b0, 1'b0);
        cycle();
        check_str("t4_order", trace, "MM-MMS");

        // Stalled output holds for three cycles; release accepts immediately.
        new_sq(1'b1);
        cycle();
        held_data = mdl_data;
        held_addr = mdl_addr;
        new_sq(1'b1);
        new_m(1'b1, 1'b1);
        i_dc_wr_stall = 1'b1;
        trace = "";
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_hold_data", {32'd0, o_dc_wr_data}, {32'd0, held_data});
            check("t5_hold_addr", {32'd0, o_dc_wr_addr}, {32'd0, held_addr});
        end
        i_dc_wr_stall = 1'b0;
        cycle();
        check_str("t5_order", trace, "---M");

        // Reset in the middle of a fill returns to arbitration.
        new_sq(1'b0);
        new_m(1'b1, 1'b0);
        trace = "";
        cycle();
        new_m(1'b1, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        check("t6_rst_en", {63'd0, o_dc_wr_en}, 64'd0);
        rst = 1'b0;
        new_m(1'b0, 1'b0);
        new_sq(1'b1);
        cycle();
        check_str("t6_order", trace, "MM-S");

        // Randomized traffic, stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (last_sq_acc || !i_sq_req_valid) new_sq($urandom_range(99) < 60);
            if (last_m_acc || !i_mshq_valid) new_m($urandom_range(99) < 55, $urandom_range(2) == 0);
            i_dc_wr_stall = ($urandom_range(99) < 30);
            rst           = ($urandom_range(199) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
